// File: rtl/evm_ballot_ctrl.sv
// Presiding-officer controller for an EVM: opens one ballot window per Issue press,
// waits for the voter's LED confirmation, and tallies and checks the counters at poll close.
module evm_ballot_ctrl #(
  parameter int CNT_W   = 7,
  parameter int TIMEOUT = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Issue,
  input  logic             Close,
  input  logic             Led_A,
  input  logic             Led_B,
  input  logic             Led_C,
  input  logic [CNT_W-1:0] CntA,
  input  logic [CNT_W-1:0] CntB,
  input  logic [CNT_W-1:0] CntC,
  output logic             ballot,
  output logic             Busy,
  output logic [CNT_W+1:0] Issued,
  output logic             Timeout,
  output logic             Multi_vote,
  output logic [1:0]       Winner,
  output logic             Tie,
  output logic             Mismatch,
  output logic             Result_valid
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CONFIRM, S_TALLY, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               issue_q, issue_req_q, close_pend_q;
  logic [7:0]         timer_q, timer_d;
  logic [SUM_W-1:0]   issued_q, issued_d;
  logic               ballot_q, timeout_q, timeout_d;
  logic               multi_q, multi_d;
  logic [1:0]         winner_q, winner_d;
  logic               tie_q, tie_d, mismatch_q, mismatch_d;

  logic               any_led, multi_led;
  logic [SUM_W-1:0]   cnt_sum;
  logic [CNT_W-1:0]   cnt_max;
  logic               hit_a, hit_b, hit_c;

  assign any_led   = Led_A | Led_B | Led_C;
  assign multi_led = (Led_A & Led_B) | (Led_A & Led_C) | (Led_B & Led_C);
  assign cnt_sum   = SUM_W'(CntA) + SUM_W'(CntB) + SUM_W'(CntC);

  always_comb begin
    cnt_max = (CntA >= CntB) ? CntA : CntB;
    if (CntC > cnt_max) cnt_max = CntC;
  end

  assign hit_a = (CntA == cnt_max);
  assign hit_b = (CntB == cnt_max);
  assign hit_c = (CntC == cnt_max);

  // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    issued_d   = issued_q;
    timeout_d  = 1'b0;
    multi_d    = multi_q;
    winner_d   = winner_q;
    tie_d      = tie_q;
    mismatch_d = mismatch_q;
    case (state_q)
      S_IDLE: begin
        if (close_pend_q) begin
          state_d = S_TALLY;
        end else if (issue_req_q) begin
          state_d = S_ARMED;
          timer_d = '0;
        end
      end
      S_ARMED: begin
        timer_d = timer_q + 8'd1;
        // A vote in the expiry cycle still counts and suppresses the timeout.
        if (any_led) begin
          if (issued_q != '1) issued_d = issued_q + SUM_W'(1);
          if (multi_led) multi_d = 1'b1;
          state_d = S_CONFIRM;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_CONFIRM: begin
        if (!any_led) state_d = S_IDLE;
      end
      S_TALLY: begin
        mismatch_d = (cnt_sum != issued_q);
        if (cnt_max == '0) begin
          winner_d = 2'b00;
          tie_d    = 1'b0;
        end else begin
          winner_d = hit_a ? 2'b01 : (hit_b ? 2'b10 : 2'b11);
          tie_d    = (hit_a & hit_b) | (hit_a & hit_c) | (hit_b & hit_c);
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      issue_q      <= 1'b0;
      issue_req_q  <= 1'b0;
      close_pend_q <= 1'b0;
      timer_q      <= '0;
      issued_q     <= '0;
      ballot_q     <= 1'b0;
      timeout_q    <= 1'b0;
      multi_q      <= 1'b0;
      winner_q     <= 2'b00;
      tie_q        <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_q      <= Issue;
      issue_req_q  <= Issue & ~issue_q;
      close_pend_q <= close_pend_q | Close;
      timer_q      <= timer_d;
      issued_q     <= issued_d;
      ballot_q     <= (state_d == S_ARMED);
      timeout_q    <= timeout_d;
      multi_q      <= multi_d;
      winner_q     <= winner_d;
      tie_q        <= tie_d;
      mismatch_q   <= mismatch_d;
    end
  end

  assign ballot       = ballot_q;
  assign Busy         = (state_q == S_ARMED) || (state_q == S_CONFIRM) || (state_q == S_TALLY);
  assign Result_valid = (state_q == S_DONE);
  assign Issued       = issued_q;
  assign Timeout      = timeout_q;
  assign Multi_vote   = multi_q;
  assign Winner       = winner_q;
  assign Tie          = tie_q;
  assign Mismatch     = mismatch_q;

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Directed bench for evm_ballot_ctrl: hand-written sequences for ballot timing corners
// plus a table of poll-close vectors with hand-computed results.
module tb_evm_ballot_ctrl;

  localparam int CNT_W   = 7;
  localparam int TIMEOUT = 16;

  logic             Clk = 1'b0;
  logic             Rst_n, Issue, Close, Led_A, Led_B, Led_C;
  logic [CNT_W-1:0] CntA, CntB, CntC;
  logic             ballot, Busy, Timeout, Multi_vote, Tie, Mismatch, Result_valid;
  logic [CNT_W+1:0] Issued;
  logic [1:0]       Winner;

  int checks   = 0;
  int failures = 0;

  evm_ballot_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Issue(Issue), .Close(Close),
    .Led_A(Led_A), .Led_B(Led_B), .Led_C(Led_C),
    .CntA(CntA), .CntB(CntB), .CntC(CntC),
    .ballot(ballot), .Busy(Busy), .Issued(Issued), .Timeout(Timeout),
    .Multi_vote(Multi_vote), .Winner(Winner), .Tie(Tie), .Mismatch(Mismatch),
    .Result_valid(Result_valid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [CNT_W-1:0] a, b, c;
    int               votes;
    logic [1:0]       win;
    logic             tie;
    logic             mis;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    Issue = 1'b0; Close = 1'b0;
    Led_A = 1'b0; Led_B = 1'b0; Led_C = 1'b0;
    CntA = '0; CntB = '0; CntC = '0;
    #12;
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
  endtask

  // Pulse Issue and wait (bounded) for the ballot window to open.
  task automatic open_ballot(input string name);
    int n;
    Issue = 1'b1;
    tick();
    Issue = 1'b0;
    n = 0;
    while (ballot !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (ballot !== 1'b1) check({name, "_open_timeout"}, 32'(ballot), 32'd1);
  endtask

  task automatic cast_vote(input logic a, input logic b, input logic c);
    open_ballot("vote");
    Led_A = a; Led_B = b; Led_C = c;
    tick();
    Led_A = 1'b0; Led_B = 1'b0; Led_C = 1'b0;
    tick();
    tick();
  endtask

  task automatic close_poll(input string name);
    int n;
    Close = 1'b1;
    tick();
    Close = 1'b0;
    n = 0;
    while (Result_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({name, "_result_valid"}, 32'(Result_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt, to_cnt, windows, seen;
    logic prev_b, to_at_fall;
    logic [CNT_W+1:0] base;

    vecs[0] = '{a: 7'd5,   b: 7'd9,   c: 7'd3,   votes: 17, win: 2'b10, tie: 1'b0, mis: 1'b0};
    vecs[1] = '{a: 7'd5,   b: 7'd9,   c: 7'd4,   votes: 17, win: 2'b10, tie: 1'b0, mis: 1'b1};
    vecs[2] = '{a: 7'd7,   b: 7'd2,   c: 7'd7,   votes: 16, win: 2'b01, tie: 1'b1, mis: 1'b0};
    vecs[3] = '{a: 7'd0,   b: 7'd0,   c: 7'd0,   votes: 0,  win: 2'b00, tie: 1'b0, mis: 1'b0};
    vecs[4] = '{a: 7'd3,   b: 7'd3,   c: 7'd3,   votes: 9,  win: 2'b01, tie: 1'b1, mis: 1'b0};
    vecs[5] = '{a: 7'd1,   b: 7'd2,   c: 7'd6,   votes: 9,  win: 2'b11, tie: 1'b0, mis: 1'b0};
    vecs[6] = '{a: 7'd127, b: 7'd127, c: 7'd127, votes: 0,  win: 2'b01, tie: 1'b1, mis: 1'b1};
    vecs[7] = '{a: 7'd0,   b: 7'd4,   c: 7'd4,   votes: 8,  win: 2'b10, tie: 1'b1, mis: 1'b0};

    // Reset values, sampled while reset is held.
    Rst_n = 1'b0;
    Issue = 1'b0; Close = 1'b0;
    Led_A = 1'b0; Led_B = 1'b0; Led_C = 1'b0;
    CntA = '0; CntB = '0; CntC = '0;
    #12;
    check("rst_ballot", 32'(ballot), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_issued", 32'(Issued), 32'd0);
    check("rst_timeout", 32'(Timeout), 32'd0);
    check("rst_multi", 32'(Multi_vote), 32'd0);
    check("rst_winner", 32'(Winner), 32'd0);
    check("rst_tie", 32'(Tie), 32'd0);
    check("rst_mismatch", 32'(Mismatch), 32'd0);
    check("rst_valid", 32'(Result_valid), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    // 1: single vote with exact ballot timing (edge register + state = two cycles).
    Issue = 1'b1;
    tick();
    check("t1_ballot_after1", 32'(ballot), 32'd0);
    tick();
    check("t1_ballot_after2", 32'(ballot), 32'd1);
    check("t1_busy_armed", 32'(Busy), 32'd1);
    Issue = 1'b0;
    Led_A = 1'b1;
    tick();
    check("t1_ballot_drop", 32'(ballot), 32'd0);
    check("t1_issued", 32'(Issued), 32'd1);
    check("t1_busy_confirm", 32'(Busy), 32'd1);
    tick();
    check("t1_hold_confirm", 32'(Busy), 32'd1);
    Led_A = 1'b0;
    tick();
    check("t1_idle_busy", 32'(Busy), 32'd0);
    check("t1_multi", 32'(Multi_vote), 32'd0);

    // 2: expiry without a vote.
    open_ballot("t2");
    hi_cnt = 1; to_cnt = 0; to_at_fall = 1'b0; prev_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ballot) hi_cnt++;
      if (Timeout) to_cnt++;
      if (prev_b && !ballot) to_at_fall = Timeout;
      prev_b = ballot;
    end
    check("t2_window_len", 32'(hi_cnt), 32'(TIMEOUT));
    check("t2_timeout_pulses", 32'(to_cnt), 32'd1);
    check("t2_timeout_at_fall", 32'(to_at_fall), 32'd1);
    check("t2_issued", 32'(Issued), 32'd1);

    // Holding Issue high yields one window only.
    Issue = 1'b1;
    windows = 0; to_cnt = 0; prev_b = ballot;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ballot && !prev_b) windows++;
      if (Timeout) to_cnt++;
      prev_b = ballot;
    end
    Issue = 1'b0;
    tick();
    check("t2_hold_windows", 32'(windows), 32'd1);
    check("t2_hold_timeouts", 32'(to_cnt), 32'd1);

    // 3: two LEDs in one cycle count once and latch Multi_vote.
    base = Issued;
    open_ballot("t3");
    Led_A = 1'b1; Led_B = 1'b1;
    tick();
    check("t3_issued_once", 32'(Issued), 32'(base) + 32'd1);
    check("t3_multi_set", 32'(Multi_vote), 32'd1);
    Led_A = 1'b0; Led_B = 1'b0;
    tick();
    tick();
    cast_vote(1'b0, 1'b1, 1'b0);
    check("t3_issued_after", 32'(Issued), 32'(base) + 32'd2);
    check("t3_multi_sticky", 32'(Multi_vote), 32'd1);

    // 4/5: poll-close vectors.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].votes; k++) cast_vote(1'b1, 1'b0, 1'b0);
      CntA = vecs[v].a; CntB = vecs[v].b; CntC = vecs[v].c;
      close_poll($sformatf("v%0d", v));
      check($sformatf("v%0d_winner", v), 32'(Winner), 32'(vecs[v].win));
      check($sformatf("v%0d_tie", v), 32'(Tie), 32'(vecs[v].tie));
      check($sformatf("v%0d_mismatch", v), 32'(Mismatch), 32'(vecs[v].mis));
      check($sformatf("v%0d_issued", v), 32'(Issued), 32'(vecs[v].votes));
      check($sformatf("v%0d_busy", v), 32'(Busy), 32'd0);
    end

    // 6: Close during an open ballot lets the vote finish first.
    do_reset();
    CntA = '0; CntB = '0; CntC = 7'd1;
    open_ballot("t6");
    Close = 1'b1;
    tick();
    Close = 1'b0;
    check("t6_ballot_kept", 32'(ballot), 32'd1);
    check("t6_no_result_yet", 32'(Result_valid), 32'd0);
    Led_C = 1'b1;
    tick();
    check("t6_vote_counted", 32'(Issued), 32'd1);
    check("t6_ballot_drop", 32'(ballot), 32'd0);
    Led_C = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !Result_valid; i++) tick();
    check("t6_result_valid", 32'(Result_valid), 32'd1);
    check("t6_winner", 32'(Winner), 32'd3);
    check("t6_mismatch", 32'(Mismatch), 32'd0);

    // Issue in DONE is ignored.
    Issue = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ballot) seen++;
    end
    Issue = 1'b0;
    check("t6_done_no_ballot", 32'(seen), 32'd0);
    check("t6_done_held", 32'(Result_valid), 32'd1);

    // Asynchronous reset in the middle of an open ballot.
    do_reset();
    cast_vote(1'b1, 1'b0, 1'b0);
    open_ballot("t6r");
    check("t6r_ballot_open", 32'(ballot), 32'd1);
    Rst_n = 1'b0;
    #1;
    check("t6r_ballot_async", 32'(ballot), 32'd0);
    check("t6r_issued", 32'(Issued), 32'd0);
    check("t6r_busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
